// File: rtl/ace_snoop_pkg.sv
// Shared types and constants for the ACE snoop controller: FSM states,
// CRRESP bit positions and ACSNOOP transaction codes.
package ace_snoop_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SNOOP    = 3'd1,
      ST_RESP     = 3'd2,
      ST_DATA     = 3'd3,
      ST_DELIVER  = 3'd4,
      ST_WAIT_ACK = 3'd5
   } state_t;

   localparam int unsigned RESP_DATA_TRANSFER = 0;
   localparam int unsigned RESP_ERROR         = 1;
   localparam int unsigned RESP_PASS_DIRTY    = 2;
   localparam int unsigned RESP_IS_SHARED     = 3;
   localparam int unsigned RESP_WAS_UNIQUE    = 4;

   localparam logic [3:0] SNP_READ_ONCE        = 4'b0000;
   localparam logic [3:0] SNP_READ_SHARED      = 4'b0001;
   localparam logic [3:0] SNP_READ_CLEAN       = 4'b0010;
   localparam logic [3:0] SNP_READ_NOT_SH_DIRTY = 4'b0011;
   localparam logic [3:0] SNP_READ_UNIQUE      = 4'b0111;
   localparam logic [3:0] SNP_CLEAN_SHARED     = 4'b1000;
   localparam logic [3:0] SNP_CLEAN_INVALID    = 4'b1001;
   localparam logic [3:0] SNP_MAKE_INVALID     = 4'b1101;
   localparam logic [3:0] SNP_DVM_COMPLETE     = 4'b1110;
   localparam logic [3:0] SNP_DVM_MESSAGE      = 4'b1111;

endpackage

// File: rtl/ace_snoop_ctrl_rr_arbiter.sv
// Pointer-based round-robin arbiter; the pointer moves to winner+1 on each grant.
module rr_arbiter #(
   parameter  int NUM_MASTERS = 8,
   localparam int IW          = $clog2(NUM_MASTERS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [NUM_MASTERS-1:0] req,
   output logic [NUM_MASTERS-1:0] gnt,
   output logic [IW-1:0]          gnt_idx,
   output logic                   gnt_any
);

   logic [IW-1:0] ptr;
   int unsigned   idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = 0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         idx = 32'(ptr) + i;
         if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
         if (en && !gnt_any && req[IW'(idx)]) begin
            gnt_any          = 1'b1;
            gnt[IW'(idx)]    = 1'b1;
            gnt_idx          = IW'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else if (gnt_any)
         ptr <= (gnt_idx == IW'(NUM_MASTERS - 1)) ? '0 : gnt_idx + 1'b1;
   end

endmodule

// File: rtl/ace_snoop_ctrl.sv
// ACE snoop controller: arbitrates coherent requests, broadcasts snoops to all
// other masters, gathers responses and line data, then returns one result.
module ace_snoop_ctrl
   import ace_snoop_pkg::*;
#(
   parameter  int NUM_MASTERS = 8,
   parameter  int ADDR_SIZE   = 32,
   parameter  int DATA_SIZE   = 128,
   parameter  int NUM_BEATS   = 4,
   localparam int IW          = $clog2(NUM_MASTERS),
   localparam int BW          = $clog2(NUM_BEATS + 1)
) (
   input  logic                             ACLK,
   input  logic                             ARESET,
   input  logic [NUM_MASTERS-1:0]           req_vld,
   output logic [NUM_MASTERS-1:0]           req_rdy,
   input  logic [NUM_MASTERS*ADDR_SIZE-1:0] req_addr,
   input  logic [NUM_MASTERS*4-1:0]         req_snoop,
   input  logic [NUM_MASTERS-1:0]           req_wr,
   output logic [NUM_MASTERS-1:0]           ACVALID,
   input  logic [NUM_MASTERS-1:0]           ACREADY,
   output logic [NUM_MASTERS*ADDR_SIZE-1:0] ACADDR,
   output logic [NUM_MASTERS*4-1:0]         ACSNOOP,
   input  logic [NUM_MASTERS-1:0]           CRVALID,
   output logic [NUM_MASTERS-1:0]           CRREADY,
   input  logic [NUM_MASTERS*5-1:0]         CRRESP,
   input  logic [NUM_MASTERS-1:0]           CDVALID,
   output logic [NUM_MASTERS-1:0]           CDREADY,
   input  logic [NUM_MASTERS*DATA_SIZE-1:0] CDDATA,
   input  logic [NUM_MASTERS-1:0]           CDLAST,
   input  logic [NUM_MASTERS-1:0]           RACK,
   input  logic [NUM_MASTERS-1:0]           WACK,
   output logic                             rsp_vld,
   input  logic                             rsp_rdy,
   output logic [NUM_BEATS*DATA_SIZE-1:0]   rsp_data,
   output logic [4:0]                       rsp_resp,
   output logic [IW-1:0]                    rsp_id
);

   state_t                         state;
   logic [NUM_MASTERS-1:0]         init_oh;
   logic [IW-1:0]                  init_idx;
   logic                           wr_q;
   logic [ADDR_SIZE-1:0]           addr_q;
   logic [3:0]                     snoop_q;
   logic [NUM_MASTERS-1:0]         ac_pend, cr_pend, cd_pend;
   logic [4:0]                     resp_or;
   logic                           short_q;
   logic [IW-1:0]                  store_idx;
   logic [BW-1:0]                  beat_cnt;
   logic [NUM_BEATS*DATA_SIZE-1:0] data_q;

   logic [NUM_MASTERS-1:0] gnt;
   logic [IW-1:0]          gnt_idx;
   logic                   gnt_any;

   logic [NUM_MASTERS-1:0] ac_left, cr_hs, cr_left, dt_vec, mask_nxt, cd_left;
   logic [4:0]             resp_acc;
   logic [IW-1:0]          low_idx;
   logic                   low_found;
   logic                   store_hs, store_last, ack;
   logic [DATA_SIZE-1:0]   cd_beat;

   rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_arb (
      .clk     (ACLK),
      .rst     (ARESET),
      .en      (state == ST_IDLE && !ARESET),
      .req     (req_vld),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   always_comb begin
      ac_left   = ac_pend & ~ACREADY;
      cr_hs     = cr_pend & CRVALID;
      cr_left   = cr_pend & ~CRVALID;
      dt_vec    = '0;
      resp_acc  = '0;
      for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
         dt_vec[m] = CRRESP[m*5 + RESP_DATA_TRANSFER];
         if (cr_hs[m]) resp_acc = resp_acc | CRRESP[m*5 +: 5];
      end
      mask_nxt  = cd_pend | (cr_hs & dt_vec);
      low_idx   = '0;
      low_found = 1'b0;
      for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
         if (!low_found && mask_nxt[m]) begin
            low_found = 1'b1;
            low_idx   = IW'(m);
         end
      end
      cd_left    = cd_pend & ~(CDVALID & CDLAST);
      cd_beat    = CDDATA[32'(store_idx)*DATA_SIZE +: DATA_SIZE];
      store_hs   = cd_pend[store_idx] && CDVALID[store_idx];
      store_last = store_hs && CDLAST[store_idx];
      ack        = wr_q ? WACK[init_idx] : RACK[init_idx];
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state     <= ST_IDLE;
         init_oh   <= '0;
         init_idx  <= '0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         snoop_q   <= '0;
         ac_pend   <= '0;
         cr_pend   <= '0;
         cd_pend   <= '0;
         resp_or   <= '0;
         short_q   <= 1'b0;
         store_idx <= '0;
         beat_cnt  <= '0;
         data_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: if (gnt_any) begin
               init_oh  <= gnt;
               init_idx <= gnt_idx;
               addr_q   <= req_addr[32'(gnt_idx)*ADDR_SIZE +: ADDR_SIZE];
               snoop_q  <= req_snoop[32'(gnt_idx)*4 +: 4];
               wr_q     <= req_wr[gnt_idx];
               ac_pend  <= ~gnt;
               cr_pend  <= '0;
               cd_pend  <= '0;
               resp_or  <= '0;
               short_q  <= 1'b0;
               beat_cnt <= '0;
               data_q   <= '0;
               state    <= ST_SNOOP;
            end
            ST_SNOOP: begin
               ac_pend <= ac_left;
               if (ac_left == '0) begin
                  cr_pend <= ~init_oh;
                  state   <= ST_RESP;
               end
            end
            ST_RESP: begin
               cr_pend <= cr_left;
               cd_pend <= mask_nxt;
               resp_or <= resp_or | resp_acc;
               if (cr_left == '0) begin
                  store_idx <= low_idx;
                  state     <= (mask_nxt != '0) ? ST_DATA : ST_DELIVER;
               end
            end
            ST_DATA: begin
               cd_pend <= cd_left;
               // Only the lowest-index supplier fills the line; the counter saturates.
               if (store_hs && 32'(beat_cnt) < NUM_BEATS) begin
                  data_q[32'(beat_cnt)*DATA_SIZE +: DATA_SIZE] <= cd_beat;
                  beat_cnt <= beat_cnt + 1'b1;
               end
               if (store_last && 32'(beat_cnt) + 1 < NUM_BEATS) short_q <= 1'b1;
               if (cd_left == '0) state <= ST_DELIVER;
            end
            ST_DELIVER:  if (rsp_rdy) state <= ST_WAIT_ACK;
            ST_WAIT_ACK: if (ack) state <= ST_IDLE;
            default:     state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      rsp_resp             = resp_or;
      rsp_resp[RESP_ERROR] = resp_or[RESP_ERROR] | short_q;
   end

   assign req_rdy  = gnt;
   assign ACVALID  = (state == ST_SNOOP) ? ac_pend : '0;
   assign ACADDR   = {NUM_MASTERS{addr_q}};
   assign ACSNOOP  = {NUM_MASTERS{snoop_q}};
   assign CRREADY  = (state == ST_RESP) ? cr_pend : '0;
   assign CDREADY  = (state == ST_DATA) ? cd_pend : '0;
   assign rsp_vld  = (state == ST_DELIVER);
   assign rsp_data = data_q;
   assign rsp_id   = init_idx;

endmodule

// File: tb/tb_ace_snoop_ctrl.sv
// Directed self-checking bench for ace_snoop_ctrl with four masters.
module tb_ace_snoop_ctrl;

   localparam int NM = 4;
   localparam int AS = 32;
   localparam int DS = 16;
   localparam int NB = 4;
   localparam int IW = 2;

   logic              ACLK = 1'b0;
   logic              ARESET;
   logic [NM-1:0]     req_vld, req_rdy, req_wr;
   logic [NM*AS-1:0]  req_addr;
   logic [NM*4-1:0]   req_snoop;
   logic [NM-1:0]     ACVALID, ACREADY;
   logic [NM*AS-1:0]  ACADDR;
   logic [NM*4-1:0]   ACSNOOP;
   logic [NM-1:0]     CRVALID, CRREADY;
   logic [NM*5-1:0]   CRRESP;
   logic [NM-1:0]     CDVALID, CDREADY, CDLAST;
   logic [NM*DS-1:0]  CDDATA;
   logic [NM-1:0]     RACK, WACK;
   logic              rsp_vld, rsp_rdy;
   logic [NB*DS-1:0]  rsp_data;
   logic [4:0]        rsp_resp;
   logic [IW-1:0]     rsp_id;

   int checks   = 0;
   int failures = 0;

   ace_snoop_ctrl #(.NUM_MASTERS(NM), .ADDR_SIZE(AS), .DATA_SIZE(DS), .NUM_BEATS(NB)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr), .req_snoop(req_snoop), .req_wr(req_wr),
      .ACVALID(ACVALID), .ACREADY(ACREADY), .ACADDR(ACADDR), .ACSNOOP(ACSNOOP),
      .CRVALID(CRVALID), .CRREADY(CRREADY), .CRRESP(CRRESP),
      .CDVALID(CDVALID), .CDREADY(CDREADY), .CDDATA(CDDATA), .CDLAST(CDLAST),
      .RACK(RACK), .WACK(WACK),
      .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_id(rsp_id)
   );

   always #5 ACLK = ~ACLK;

   task automatic tick;
      @(posedge ACLK);
      #2;
   endtask

   task automatic init_inputs;
      ARESET = 1'b0; req_vld = '0; req_wr = '0; req_addr = '0; req_snoop = '0;
      ACREADY = '1; CRVALID = '1; CRRESP = '0; CDVALID = '0; CDDATA = '0; CDLAST = '0;
      RACK = '0; WACK = '0; rsp_rdy = 1'b1;
   endtask

   task automatic test_reset;
      ARESET = 1'b1; req_vld = 4'b1111;
      tick; tick; #1;
      checks++; if (req_rdy !== 4'b0000) begin failures++; $display("FAIL rst_req_rdy got=%b exp=%b", req_rdy, 4'b0000); end
      checks++; if (ACVALID !== 4'b0000) begin failures++; $display("FAIL rst_acvalid got=%b exp=%b", ACVALID, 4'b0000); end
      checks++; if (CRREADY !== 4'b0000 || CDREADY !== 4'b0000) begin failures++; $display("FAIL rst_cr_cd got=%b/%b exp=0000/0000", CRREADY, CDREADY); end
      checks++; if (rsp_vld !== 1'b0 || rsp_data !== 64'h0 || rsp_resp !== 5'b0 || rsp_id !== 2'd0) begin failures++; $display("FAIL rst_rsp got=%b/%h/%b/%0d exp=0/0/0/0", rsp_vld, rsp_data, rsp_resp, rsp_id); end
      ARESET = 1'b0; req_vld = '0;
      tick;
   endtask

   task automatic test_basic;
      req_addr[1*AS +: AS] = 32'h0000_1000; req_snoop[1*4 +: 4] = 4'b0001; req_wr = '0;
      req_vld = 4'b0010; #1;
      checks++; if (req_rdy !== 4'b0010) begin failures++; $display("FAIL basic_grant_c0 got=%b exp=%b", req_rdy, 4'b0010); end
      tick; req_vld = '0; #1;
      checks++; if (ACVALID !== 4'b1101) begin failures++; $display("FAIL basic_acvalid_c1 got=%b exp=%b", ACVALID, 4'b1101); end
      checks++; if (ACADDR[0 +: AS] !== 32'h1000 || ACSNOOP[3*4 +: 4] !== 4'b0001) begin failures++; $display("FAIL basic_acaddr got=%h/%b exp=1000/0001", ACADDR[0 +: AS], ACSNOOP[3*4 +: 4]); end
      checks++; if (req_rdy !== 4'b0000) begin failures++; $display("FAIL basic_grant_pulse got=%b exp=%b", req_rdy, 4'b0000); end
      tick; #1;
      checks++; if (CRREADY !== 4'b1101 || ACVALID !== 4'b0000) begin failures++; $display("FAIL basic_crready_c2 got=%b/%b exp=1101/0000", CRREADY, ACVALID); end
      tick; #1;
      checks++; if (rsp_vld !== 1'b1) begin failures++; $display("FAIL basic_rsp_vld_c3 got=%b exp=1", rsp_vld); end
      checks++; if (rsp_data !== 64'h0 || rsp_id !== 2'd1 || rsp_resp !== 5'b0) begin failures++; $display("FAIL basic_rsp got=%h/%0d/%b exp=0/1/00000", rsp_data, rsp_id, rsp_resp); end
      tick; #1;
      checks++; if (rsp_vld !== 1'b0) begin failures++; $display("FAIL basic_rsp_done got=%b exp=0", rsp_vld); end
      RACK = 4'b0010; tick; RACK = '0;
   endtask

   task automatic test_data;
      CRRESP = '0; CRRESP[3*5 +: 5] = 5'b00001; rsp_rdy = 1'b0;
      req_addr[2*AS +: AS] = 32'h0000_2040; req_snoop[2*4 +: 4] = 4'b0111;
      req_vld = 4'b0100; #1;
      checks++; if (req_rdy !== 4'b0100) begin failures++; $display("FAIL data_grant got=%b exp=%b", req_rdy, 4'b0100); end
      tick; req_vld = '0; tick; tick; #1;
      checks++; if (CDREADY !== 4'b1000) begin failures++; $display("FAIL data_cdready got=%b exp=%b", CDREADY, 4'b1000); end
      for (int b = 0; b < 4; b++) begin
         CDVALID = 4'b1000; CDDATA[3*DS +: DS] = 16'(16'hA + b); CDLAST = (b == 3) ? 4'b1000 : 4'b0000;
         tick;
      end
      CDVALID = '0; CDLAST = '0; #1;
      checks++; if (rsp_vld !== 1'b1 || rsp_id !== 2'd2) begin failures++; $display("FAIL data_rsp_vld got=%b/%0d exp=1/2", rsp_vld, rsp_id); end
      checks++; if (rsp_data !== 64'h000D_000C_000B_000A) begin failures++; $display("FAIL data_beats got=%h exp=%h", rsp_data, 64'h000D_000C_000B_000A); end
      checks++; if (rsp_resp !== 5'b00001) begin failures++; $display("FAIL data_resp got=%b exp=%b", rsp_resp, 5'b00001); end
      tick; #1;
      checks++; if (rsp_vld !== 1'b1 || rsp_data !== 64'h000D_000C_000B_000A) begin failures++; $display("FAIL data_hold got=%b/%h exp=1/000d000c000b000a", rsp_vld, rsp_data); end
      rsp_rdy = 1'b1; tick; #1;
      checks++; if (rsp_vld !== 1'b0) begin failures++; $display("FAIL data_rsp_done got=%b exp=0", rsp_vld); end
      RACK = 4'b0100; tick; RACK = '0; CRRESP = '0;
   endtask

   task automatic test_round_robin;
      logic [3:0] exp_g;
      int         wait_cnt;
      ARESET = 1'b1; tick; ARESET = 1'b0;
      RACK = '1; WACK = '1; req_vld = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         exp_g = 4'b0001 << (g % 4);
         wait_cnt = 0;
         #1;
         while (req_rdy === 4'b0000 && wait_cnt < 20) begin tick; #1; wait_cnt++; end
         checks++; if (req_rdy !== exp_g) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", g, req_rdy, exp_g); end
         tick;
      end
      req_vld = '0;
      repeat (6) tick;
      RACK = '0; WACK = '0;
   endtask

   task automatic test_ac_delay;
      logic [3:0] exp_ac;
      ACREADY = 4'b1110; req_vld = 4'b0010; #1;
      checks++; if (req_rdy !== 4'b0010) begin failures++; $display("FAIL acd_grant got=%b exp=%b", req_rdy, 4'b0010); end
      tick; req_vld = '0;
      for (int k = 1; k <= 10; k++) begin
         if (k == 10) ACREADY = 4'b1111;
         #1;
         exp_ac = (k == 1) ? 4'b1101 : 4'b0001;
         checks++; if (ACVALID !== exp_ac) begin failures++; $display("FAIL acd_acvalid_c%0d got=%b exp=%b", k, ACVALID, exp_ac); end
         checks++; if (CRREADY !== 4'b0000) begin failures++; $display("FAIL acd_crready_early_c%0d got=%b exp=0000", k, CRREADY); end
         tick;
      end
      #1;
      checks++; if (CRREADY !== 4'b1101 || ACVALID !== 4'b0000) begin failures++; $display("FAIL acd_resp_entry got=%b/%b exp=1101/0000", CRREADY, ACVALID); end
      tick; tick; RACK = 4'b0010; tick; RACK = '0;
   endtask

   task automatic test_reset_mid;
      CRRESP = '0; CRRESP[1*5 +: 5] = 5'b00001;
      req_addr[0 +: AS] = 32'hDEAD_0040; req_snoop[0 +: 4] = 4'b0001;
      req_vld = 4'b0001; #1;
      checks++; if (req_rdy !== 4'b0001) begin failures++; $display("FAIL rmid_grant got=%b exp=%b", req_rdy, 4'b0001); end
      tick; req_vld = '0; tick; tick;
      CDVALID = 4'b0010; CDDATA[1*DS +: DS] = 16'h0031; tick;
      CDDATA[1*DS +: DS] = 16'h0032; tick;
      CDDATA[1*DS +: DS] = 16'h0033; ARESET = 1'b1; req_vld = 4'b0001; tick;
      CDVALID = '0; #1;
      checks++; if (req_rdy !== 4'b0000) begin failures++; $display("FAIL rmid_no_grant_in_reset got=%b exp=0000", req_rdy); end
      checks++; if (ACVALID !== 4'b0000 || CRREADY !== 4'b0000 || CDREADY !== 4'b0000) begin failures++; $display("FAIL rmid_handshakes got=%b/%b/%b exp=0", ACVALID, CRREADY, CDREADY); end
      checks++; if (rsp_vld !== 1'b0 || rsp_data !== 64'h0 || rsp_resp !== 5'b0 || rsp_id !== 2'd0) begin failures++; $display("FAIL rmid_rsp got=%b/%h/%b/%0d exp=0/0/0/0", rsp_vld, rsp_data, rsp_resp, rsp_id); end
      checks++; if (ACADDR !== 128'h0 || ACSNOOP !== 16'h0) begin failures++; $display("FAIL rmid_acaddr got=%h/%h exp=0/0", ACADDR, ACSNOOP); end
      ARESET = 1'b0; CRRESP = '0; req_vld = 4'b0100; #1;
      checks++; if (req_rdy !== 4'b0100) begin failures++; $display("FAIL rmid_fresh_grant got=%b exp=%b", req_rdy, 4'b0100); end
      tick; req_vld = '0; tick; tick; #1;
      checks++; if (rsp_vld !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 64'h0 || rsp_resp !== 5'b0) begin failures++; $display("FAIL rmid_fresh_rsp got=%b/%0d/%h/%b exp=1/2/0/0", rsp_vld, rsp_id, rsp_data, rsp_resp); end
      tick; RACK = 4'b0100; tick; RACK = '0;
   endtask

   task automatic test_early_last_wrong_ack;
      CRRESP = '0; CRRESP[0 +: 5] = 5'b00001; CRRESP[1*5 +: 5] = 5'b01001;
      rsp_rdy = 1'b0; req_wr = 4'b1000; req_vld = 4'b1000; #1;
      checks++; if (req_rdy !== 4'b1000) begin failures++; $display("FAIL early_grant got=%b exp=%b", req_rdy, 4'b1000); end
      tick; req_vld = '0; tick; tick; #1;
      checks++; if (CDREADY !== 4'b0011) begin failures++; $display("FAIL early_cdready got=%b exp=%b", CDREADY, 4'b0011); end
      CDVALID = 4'b0011; CDDATA[0 +: DS] = 16'h0011; CDDATA[1*DS +: DS] = 16'h0077; CDLAST = 4'b0010;
      tick;
      CDVALID = 4'b0001; CDDATA[0 +: DS] = 16'h0022; CDLAST = 4'b0001; #1;
      checks++; if (CDREADY !== 4'b0001) begin failures++; $display("FAIL early_cdready2 got=%b exp=%b", CDREADY, 4'b0001); end
      tick;
      CDVALID = '0; CDLAST = '0; #1;
      checks++; if (rsp_vld !== 1'b1 || rsp_id !== 2'd3) begin failures++; $display("FAIL early_rsp_vld got=%b/%0d exp=1/3", rsp_vld, rsp_id); end
      checks++; if (rsp_data !== 64'h0000_0000_0022_0011) begin failures++; $display("FAIL early_beats got=%h exp=%h", rsp_data, 64'h0000_0000_0022_0011); end
      checks++; if (rsp_resp !== 5'b01011) begin failures++; $display("FAIL early_resp got=%b exp=%b", rsp_resp, 5'b01011); end
      rsp_rdy = 1'b1; tick;
      WACK = 4'b0001; RACK = 4'b1000; req_vld = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (req_rdy !== 4'b0000 || rsp_vld !== 1'b0) begin failures++; $display("FAIL wack_wrong_c%0d got=%b/%b exp=0000/0", k, req_rdy, rsp_vld); end
         tick;
      end
      WACK = 4'b1000; tick;
      WACK = '0; RACK = '0; #1;
      checks++; if (req_rdy !== 4'b0001) begin failures++; $display("FAIL wack_exit_grant got=%b exp=%b", req_rdy, 4'b0001); end
      req_vld = '0; CRRESP = '0; req_wr = '0;
   endtask

   initial begin
      init_inputs();
      test_reset();
      test_basic();
      test_data();
      test_round_robin();
      test_ac_delay();
      test_reset_mid();
      test_early_last_wrong_ack();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ace_snoop_ctrl.md
ACE_SNOOP_CTRL -- requirements
Module: ace_snoop_ctrl

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 8, coherent master count, legal range 2..16.
REQ-002 SHALL have parameter ADDR_SIZE, default 32, snoop address width.
REQ-003 SHALL have parameter DATA_SIZE, default 128, CDDATA beat width per master.
REQ-004 SHALL have parameter NUM_BEATS, default 4, beats per cache line; IW = $clog2(NUM_MASTERS).
REQ-005 SHALL have port ACLK  in  1  sole clock, all logic rising-edge.
REQ-006 SHALL have port ARESET  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port req_vld  in  NUM_MASTERS  coherent request pending per master.
REQ-008 SHALL have port req_rdy  out  NUM_MASTERS  one-cycle grant pulse per master.
REQ-009 SHALL have port req_addr  in  NUM_MASTERS*ADDR_SIZE  request line address per master.
REQ-010 SHALL have port req_snoop  in  NUM_MASTERS*4  ACSNOOP code to broadcast per master.
REQ-011 SHALL have port req_wr  in  NUM_MASTERS  1 = write-channel request (WACK), 0 = read (RACK).
REQ-012 SHALL have ports ACVALID out NM, ACREADY in NM, ACADDR out NM*ADDR_SIZE, ACSNOOP out NM*4: snoop address channel per master.
REQ-013 SHALL have ports CRVALID in NM, CRREADY out NM, CRRESP in NM*5: snoop response channel per master.
REQ-014 SHALL have ports CDVALID in NM, CDREADY out NM, CDDATA in NM*DATA_SIZE, CDLAST in NM: snoop data channel per master.
REQ-015 SHALL have ports RACK in NM, WACK in NM: initiator completion acknowledges.
REQ-016 SHALL have ports rsp_vld out 1, rsp_rdy in 1: aggregated result handshake.
REQ-017 SHALL have ports rsp_data out NUM_BEATS*DATA_SIZE (beat 0 in LSBs), rsp_resp out 5 (OR of all CRRESP), rsp_id out IW (initiator index).

Function
REQ-018 SHALL run FSM IDLE -> SNOOP -> RESP -> DATA -> DELIVER -> WAIT_ACK -> IDLE, one transaction in flight.
REQ-019 SHALL in IDLE grant via round-robin among req_vld, pulse req_rdy[winner] one cycle, capture addr/snoop/wr/index; priority pointer becomes winner+1 mod NUM_MASTERS.
REQ-020 SHALL in SNOOP drive ACVALID to every master except initiator simultaneously with captured ACADDR/ACSNOOP; each bit clears on its own ACVALID&&ACREADY; exit when all cleared; ACVALID never asserted to initiator.
REQ-021 SHALL in RESP hold CRREADY high for each non-initiator not yet responded, latch CRRESP per master, exit when all responded; CRVALID before RESP is not accepted.
REQ-022 SHALL build data mask from CRRESP[0] (DataTransfer); empty mask skips DATA, rsp_data = 0.
REQ-023 SHALL in DATA assert CDREADY to masked masters until their CDLAST beat; store beats only from lowest-index masked master into beat counter slot, others discarded.
REQ-024 SHALL saturate beat counter at NUM_BEATS (extra beats discarded); CDLAST before NUM_BEATS leaves missing beats zero and sets rsp_resp[1].
REQ-025 SHALL in DELIVER hold rsp_vld and stable rsp_* until rsp_rdy; rsp_rdy already high completes in first cycle.
REQ-026 SHALL in WAIT_ACK wait for RACK[init] (req_wr=0) or WACK[init] (req_wr=1); acks to other masters or in other states ignored; no new grant before exit.
REQ-027 SHALL, all readies high and empty mask, have req_rdy at cycle 0, ACVALID cycle 1, CRREADY cycle 2, rsp_vld cycle 3.

Reset
REQ-028 SHALL on ARESET at a rising edge force state IDLE, pointer 0, all outputs 0 next cycle, aborting any transaction mid-flight.
REQ-029 SHALL grant no request in the cycle ARESET is high.

Structure
REQ-030 SHALL place state enum, CRRESP bit indices (DataTransfer 0, Error 1, PassDirty 2, IsShared 3, WasUnique 4) and ACSNOOP codes in package ace_snoop_pkg.
REQ-031 SHALL implement arbitration in one sub-module rr_arbiter (NUM_MASTERS-wide, pointer-based).

Verification
REQ-032 SHALL test NM=4, m1 ReadShared addr 0x1000, all CRRESP=0 -> ACVALID=4'b1101, rsp_vld cycle 3, rsp_data 0, rsp_id 1.
REQ-033 SHALL test m2 req, m3 CRRESP=5'b00001 with 4 beats 0xA..0xD -> rsp_data beats A,B,C,D, rsp_resp 5'b00001.
REQ-034 SHALL test req_vld=4'b1111 held -> grants 0,1,2,3,0 in order.
REQ-035 SHALL test m0 ACREADY delayed 10 cycles -> ACVALID[0] held 10 cycles, others cleared on handshake, RESP entered after.
REQ-036 SHALL test ARESET in DATA beat 2 -> next cycle all outputs 0, state IDLE, fresh request completes normally.
REQ-037 SHALL test early CDLAST at beat 1 -> beats 2..3 zero, rsp_resp[1]=1; WACK to wrong master -> no exit from WAIT_ACK.
